// File: rtl/bip_control_unit_if.sv
// rtl/bip_control_unit_if.sv - BIP control unit program-memory / datapath bundle
interface bip_control_unit_if #(
    parameter int AB = 11,
    parameter int DB = 16
);
    logic          start;
    logic [DB-1:0] instr;
    logic [AB-1:0] pm_addr;
    logic [AB-1:0] operand;
    logic [1:0]    sel_a;
    logic          sel_b;
    logic          alu_op;
    logic          wr_acc;
    logic          wr_ram;
    logic          rd_ram;
    logic          halted;
    logic [DB-1:0] clk_count;
    logic [DB-1:0] instr_count;

    modport master (
        input  start, instr,
        output pm_addr, operand, sel_a, sel_b, alu_op,
        output wr_acc, wr_ram, rd_ram, halted, clk_count, instr_count
    );

    modport slave (
        output start, instr,
        input  pm_addr, operand, sel_a, sel_b, alu_op,
        input  wr_acc, wr_ram, rd_ram, halted, clk_count, instr_count
    );
endinterface

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP accumulator processor fetch/decode/exec sequencer
module bip_control_unit #(
    parameter int AB  = 11,
    parameter int DB  = 16,
    parameter int OPB = 5
) (
    input  logic               clk,
    input  logic               reset,
    bip_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [OPB-1:0] OP_HLT  = OPB'(0);
    localparam logic [OPB-1:0] OP_STO  = OPB'(1);
    localparam logic [OPB-1:0] OP_LD   = OPB'(2);
    localparam logic [OPB-1:0] OP_LDI  = OPB'(3);
    localparam logic [OPB-1:0] OP_ADD  = OPB'(4);
    localparam logic [OPB-1:0] OP_ADDI = OPB'(5);
    localparam logic [OPB-1:0] OP_SUB  = OPB'(6);
    localparam logic [OPB-1:0] OP_SUBI = OPB'(7);

    localparam logic [AB-1:0] PC_ONE  = AB'(1);
    localparam logic [DB-1:0] CNT_ONE = DB'(1);

    state_t         state;
    state_t         state_next;
    logic [AB-1:0]  pc;
    logic [DB-1:0]  ir;
    logic [DB-1:0]  clk_count;
    logic [DB-1:0]  instr_count;
    logic [OPB-1:0] opcode;
    logic           active;

    logic [1:0]     sel_a;
    logic           sel_b;
    logic           alu_op;
    logic           wr_acc;
    logic           wr_ram;
    logic           rd_ram;

    assign opcode = ir[DB-1:AB];
    assign active = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes come only from state and IR, so reset (which clears state
    // asynchronously) drops them without waiting for a clock edge.
    always_comb begin
        state_next = state;
        sel_a      = 2'd0;
        sel_b      = 1'b0;
        alu_op     = 1'b0;
        wr_acc     = 1'b0;
        wr_ram     = 1'b0;
        rd_ram     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
                case (opcode)
                    OP_STO: begin
                        wr_ram = 1'b1;
                    end
                    OP_LD: begin
                        rd_ram = 1'b1;
                        sel_a  = 2'd0;
                        wr_acc = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a  = 2'd1;
                        wr_acc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rd_ram = 1'b1;
                        sel_b  = 1'b0;
                        sel_a  = 2'd2;
                        alu_op = (opcode == OP_SUB);
                        wr_acc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_b  = 1'b1;
                        sel_a  = 2'd2;
                        alu_op = (opcode == OP_SUBI);
                        wr_acc = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            ir          <= '0;
            clk_count   <= '0;
            instr_count <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir <= bus.instr;
                pc <= pc + PC_ONE;
            end
            if (active) begin
                clk_count <= clk_count + CNT_ONE;
            end
            if (state == S_EXEC) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

    assign bus.pm_addr     = pc;
    assign bus.operand     = ir[AB-1:0];
    assign bus.sel_a       = sel_a;
    assign bus.sel_b       = sel_b;
    assign bus.alu_op      = alu_op;
    assign bus.wr_acc      = wr_acc;
    assign bus.wr_ram      = wr_ram;
    assign bus.rd_ram      = rd_ram;
    assign bus.halted      = (state == S_HALT);
    assign bus.clk_count   = clk_count;
    assign bus.instr_count = instr_count;
endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - self-checking bench for bip_control_unit
module tb_bip_control_unit;
    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:2047];

    bip_control_unit_if #(.AB(11), .DB(16)) ifc ();

    bip_control_unit #(.AB(11), .DB(16), .OPB(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // synchronous-read program memory
    always @(posedge clk) ifc.instr <= mem[ifc.pm_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {sel_a[1:0], sel_b, alu_op, wr_acc, wr_ram, rd_ram}
    function automatic logic [6:0] ctl_obs();
        return {ifc.sel_a, ifc.sel_b, ifc.alu_op, ifc.wr_acc, ifc.wr_ram, ifc.rd_ram};
    endfunction

    function automatic logic [6:0] exp_ctl(input logic [4:0] op);
        case (op)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_0_1_0_1;
            5'd3:    return 7'b01_0_0_1_0_0;
            5'd4:    return 7'b10_0_0_1_0_1;
            5'd5:    return 7'b10_1_0_1_0_0;
            5'd6:    return 7'b10_0_1_1_0_1;
            5'd7:    return 7'b10_1_1_1_0_0;
            default: return 7'b0;
        endcase
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_pm_addr"}, 32'(ifc.pm_addr), 32'd0);
        check({pfx, "_operand"}, 32'(ifc.operand), 32'd0);
        check({pfx, "_ctl"}, 32'(ctl_obs()), 32'd0);
        check({pfx, "_halted"}, 32'(ifc.halted), 32'd0);
        check({pfx, "_clk_count"}, 32'(ifc.clk_count), 32'd0);
        check({pfx, "_instr_count"}, 32'(ifc.instr_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) mem[i] = w;
    endtask

    // Reference: instructions execute sequentially from address 0, three cycles
    // each, until an HLT opcode; strobes follow the opcode table in EXEC only.
    task automatic run_prog(input int exp_n, input bit patch0);
        int          pc;
        int          n;
        bit          done;
        logic [15:0] w;
        do_reset();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        pc = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 2200) begin
            w = mem[pc];
            check("fetch_pm_addr", 32'(ifc.pm_addr), 32'(pc));
            check("fetch_ctl", 32'(ctl_obs()), 32'd0);
            @(negedge clk);
            check("decode_ctl", 32'(ctl_obs()), 32'd0);
            @(negedge clk);
            check("exec_ctl", 32'(ctl_obs()), 32'(exp_ctl(w[15:11])));
            check("exec_operand", 32'(ifc.operand), 32'(w[10:0]));
            check("exec_instr_count", 32'(ifc.instr_count), 32'(n));
            check("exec_clk_count", 32'(ifc.clk_count), 32'(3 * n + 2));
            check("exec_halted", 32'(ifc.halted), 32'd0);
            n++;
            pc = (pc + 1) % 2048;
            done = (w[15:11] == 5'd0);
            if (patch0 && n == 1) mem[0] = 16'h0000;
            @(negedge clk);
        end
        if (!done) check("halt_reached", 32'd0, 32'd1);
        check("halted", 32'(ifc.halted), 32'd1);
        check("final_instr_count", 32'(ifc.instr_count), 32'(n));
        check("final_clk_count", 32'(ifc.clk_count), 32'(3 * n));
        if (exp_n >= 0) check("instr_count_expected", 32'(ifc.instr_count), 32'(exp_n));
        ifc.start = 1'b1;
        repeat (3) @(negedge clk);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        check("halt_start_halted", 32'(ifc.halted), 32'd1);
        check("halt_start_instr_count", 32'(ifc.instr_count), 32'(n));
        check("halt_start_clk_count", 32'(ifc.clk_count), 32'(3 * n));
        check("halt_start_pm_addr", 32'(ifc.pm_addr), 32'(pc));
        check("halt_start_ctl", 32'(ctl_obs()), 32'd0);
    endtask

    task automatic reset_mid_add();
        fill_mem(16'h0000);
        mem[0] = 16'h1801;
        mem[1] = 16'h2004;
        do_reset();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_add_wr_acc", 32'(ifc.wr_acc), 32'd1);
        check("mid_add_rd_ram", 32'(ifc.rd_ram), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_wr_acc", 32'(ifc.wr_acc), 32'd0);
        check("async_rd_ram", 32'(ifc.rd_ram), 32'd0);
        check_reset_vals("async");
        run_prog(3, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        ifc.start = 1'b0;
        fill_mem(16'h0000);
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_reset_vals("idle");
        end

        fill_mem(16'h0000);
        mem[0] = 16'h1805;
        mem[1] = 16'h2FFE;
        mem[2] = 16'h0803;
        run_prog(4, 1'b0);

        fill_mem(16'h0000);
        mem[0] = 16'h1007;
        mem[1] = 16'h3008;
        run_prog(3, 1'b0);

        fill_mem(16'h0000);
        mem[0] = 16'hF800;
        run_prog(2, 1'b0);

        for (int p = 0; p < 8; p++) begin
            int          len;
            logic [4:0]  op;
            logic [10:0] opr;
            fill_mem(16'h0000);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                op  = 5'($urandom_range(1, 31));
                opr = 11'($urandom());
                mem[i] = {op, opr};
            end
            run_prog(len + 1, 1'b0);
        end

        fill_mem(16'hF800);
        run_prog(2049, 1'b1);

        reset_mid_add();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Sequencing and decode stage of the BIP accumulator processor. It fetches 16-bit instruction words from the synchronous-read program memory and holds them in an instruction register. It splits each word into a 5-bit opcode and an 11-bit operand; the operand feeds `Signal_Extension` directly. The opcode is decoded into one-cycle datapath strobes for the accumulator, ALU and data RAM.

## Interface
Parameters:
- `AB`, 11, program counter / operand width (must equal `Signal_Extension.AB`)
- `DB`, 16, instruction word and counter width
- `OPB`, 5, opcode width; `OPB + AB == DB` is required

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin execution; sampled only in IDLE
- `instr`  in  DB  program memory read data; valid one cycle after `pm_addr` is presented
- `pm_addr`  out  AB  program memory address (= PC)
- `operand`  out  AB  IR[AB-1:0]; drives `Signal_Extension.Addr` and the data RAM address
- `sel_a`  out  2  accumulator input mux: 0 = RAM data, 1 = extended operand, 2 = ALU result
- `sel_b`  out  1  ALU B input: 0 = RAM data, 1 = extended operand
- `alu_op`  out  1  0 = add, 1 = subtract
- `wr_acc`  out  1  accumulator write strobe
- `wr_ram`  out  1  data RAM write strobe (data = accumulator)
- `rd_ram`  out  1  data RAM read enable; the RAM is combinational-read
- `halted`  out  1  high in HALT
- `clk_count`  out  DB  cycles spent in FETCH/DECODE/EXEC
- `instr_count`  out  DB  instructions executed, including HLT

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: waits for `start` = 1, then goes to FETCH. In all other states `start` has no effect.
- FETCH: drives `pm_addr` = PC, then goes to DECODE.
- DECODE: `instr` is valid in this cycle. At the end of the cycle, IR <= `instr` and PC <= PC + 1. PC wraps from 2^AB-1 to 0 with no flag. Then goes to EXEC.
- EXEC: decodes IR[DB-1:AB]. Strobes are high for exactly this one cycle. `instr_count` increments. Next state is HALT if the opcode is HLT, otherwise FETCH.
- Decode (all outputs not listed are 0):
  - 00000 HLT: no strobes.
  - 00001 STO: `wr_ram`.
  - 00010 LD: `rd_ram`, `sel_a`=0, `wr_acc`.
  - 00011 LDI: `sel_a`=1, `wr_acc`.
  - 00100 ADD: `rd_ram`, `sel_b`=0, `sel_a`=2, `alu_op`=0, `wr_acc`.
  - 00101 ADDI: `sel_b`=1, `sel_a`=2, `alu_op`=0, `wr_acc`.
  - 00110 SUB: as ADD with `alu_op`=1.
  - 00111 SUBI: as ADDI with `alu_op`=1.
  - Any other opcode: NOP. It returns to FETCH, no strobes, but is still counted.
- Outside EXEC, all strobes, `sel_a`, `sel_b` and `alu_op` are 0.
- `operand` is always IR[AB-1:0], stable from DECODE's clock edge until the next DECODE edge.
- HALT: terminal state. Only `reset` leaves it. Counters freeze.
- `clk_count` increments on every cycle whose state is FETCH, DECODE or EXEC. Both counters wrap modulo 2^DB.

## Timing
- Reset values (applied immediately on `reset` rise, independent of `clk`): state = IDLE, PC = 0, IR = 0, `pm_addr` = 0, `operand` = 0, all strobes 0, `sel_a` = 0, `sel_b` = 0, `alu_op` = 0, `halted` = 0, both counters 0.
- Reset asserted mid-instruction (any state) aborts the instruction. No strobe may glitch high during reset.
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). After a `start` seen in IDLE at edge N, the first EXEC cycle is cycle N+3.
- `halted` rises on the edge that ends HLT's EXEC cycle.
- Strobes are decoded from IR and state only, never from `instr`, so they are glitch-free with respect to memory output changes.

## Test plan
- Reset/idle: hold `reset` for 2 cycles, then idle 5 cycles with `start` = 0 -> all outputs at reset values, `clk_count` = 0, `pm_addr` = 0.
- Straight program: LDI 5 (0x1805), ADDI -2 (0x2FFE), STO 3 (0x0803), HLT (0x0000), then pulse `start` -> EXEC strobes in order: {`wr_acc`, `sel_a`=1, `operand`=0x005}; {`wr_acc`, `sel_a`=2, `sel_b`=1, `alu_op`=0, `operand`=0x7FE}; {`wr_ram`, `operand`=0x003}; none. Then `halted` = 1, `instr_count` = 4, `clk_count` = 12.
- SUB/LD coverage: LD 7, SUB 8, HLT -> `rd_ram` high in both EXEC cycles. SUB has `alu_op` = 1 and `sel_b` = 0. `instr_count` = 3.
- Illegal opcode 0x F800 (opcode 11111) followed by HLT -> no strobes for 0xF800, execution continues, `instr_count` = 2.
- PC wrap: a memory model returning NOP everywhere except HLT at address 0, with PC run past 0x7FF -> `pm_addr` goes 0x7FF to 0x000 and the HLT executes. Also `start` asserted again in HALT -> ignored.
- Async reset mid-EXEC of an ADD -> `wr_acc`/`rd_ram` drop the same cycle without a clock edge, state = IDLE, PC = 0, and a fresh `start` re-executes from address 0.
